// File: rtl/datapath.sv
// datapath: BIP accumulator, add/sub ALU, internal data RAM and retired-instruction counter.
module datapath #(
    parameter int RAM_DEPTH = 1024,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel_a,
    input  logic             sel_b,
    input  logic             wr_acc,
    input  logic             op,
    input  logic             wr_ram,
    input  logic             rd_ram,
    input  logic             wr_pc,
    input  logic [10:0]      operand,
    output logic [15:0]      acc,
    output logic [CNT_W-1:0] inst_count
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam logic [11:0] DEPTH = 12'(RAM_DEPTH);
    logic [15:0] mem [RAM_DEPTH];
    logic [15:0] imm, ram_q, alu_b, alu_y, acc_d;
    logic        in_range;
    always_comb begin
        imm      = {{5{operand[10]}}, operand};
        in_range = {1'b0, operand} < DEPTH;
        ram_q    = (rd_ram && in_range) ? mem[operand[AW-1:0]] : 16'h0000;
        alu_b    = sel_b ? imm : ram_q;
        alu_y    = op ? acc - alu_b : acc + alu_b;
        acc_d    = sel_a == 2'b00 ? ram_q :
                   sel_a == 2'b01 ? imm   :
                   sel_a == 2'b10 ? alu_y : acc;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc        <= 16'h0000;
            inst_count <= '0;
        end else begin
            if (wr_acc) acc <= acc_d;
            if (wr_pc) inst_count <= inst_count + CNT_W'(1);
        end
    // RAM is not reset; the store simply suppressed while reset is high
    always_ff @(posedge clk)
        if (wr_ram && in_range && !reset) mem[operand[AW-1:0]] <= acc;
endmodule

// File: doc/datapath.md
# datapath

Accumulator datapath of the BIP processor, directly downstream of `control`. It consumes the decoded control word (`sel_a`, `sel_b`, `wr_acc`, `op`, `wr_ram`, `rd_ram`, `wr_pc`) and the 11-bit `operand`. It holds the accumulator, the add/sub ALU and the internal data RAM, and exports the accumulator and an executed-instruction counter for the debug unit. All instructions complete in one clock.

## Interface
- `RAM_DEPTH`, 1024: data RAM words, power of two, at most 2048.
- `CNT_W`, 32: width of `inst_count`.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `sel_a` input 2: accumulator source. 00 is RAM data, 01 is sign-extended operand, 10 is ALU result, 11 holds the accumulator.
- `sel_b` input 1: ALU B source. 0 is RAM data, 1 is sign-extended operand.
- `wr_acc` input 1: accumulator write enable.
- `op` input 1: ALU operation. 0 is A+B, 1 is A−B.
- `wr_ram` input 1: data RAM write enable.
- `rd_ram` input 1: data RAM read enable.
- `wr_pc` input 1: instruction-retire strobe; 0 means halted.
- `operand` input 11: data address and immediate.
- `acc` output 16: accumulator register.
- `inst_count` output CNT_W: count of retired instructions.

## Operation
- Sign extension: `imm = {{5{operand[10]}}, operand}`.
- RAM read is combinational. `ram_q = mem[operand]` when `rd_ram=1` and `operand < RAM_DEPTH`; otherwise `ram_q = 16'h0000`.
- ALU: A is always `acc`. B is `ram_q` when `sel_b=0`, `imm` when `sel_b=1`.
  - Result is 16-bit two's complement. Carry and overflow are discarded, so values wrap modulo 2^16.
- Accumulator:
  - When `wr_acc=1`, on the clock edge `acc` takes the `sel_a` mux output.
  - When `wr_acc=0`, `acc` holds.
  - With `sel_a=11`, `acc` holds even when `wr_acc=1`.
- RAM write: when `wr_ram=1` and `operand < RAM_DEPTH`, on the clock edge `mem[operand] <= acc`, using the pre-edge value of `acc`.
  - Writes with `operand >= RAM_DEPTH` are ignored.
- Simultaneous `wr_ram` and `wr_acc`:
  - RAM stores the old `acc`; `acc` takes the new value.
  - A read of the address being written returns the old contents in that cycle.
- `inst_count` increments by 1 on each edge where `wr_pc=1`. It wraps from all-ones to 0 and holds while `wr_pc=0`.
- Reset (asynchronous, any time, including mid-instruction):
  - `acc=16'h0000` and `inst_count=0` immediately; both hold while `reset=1`.
  - RAM contents are not cleared.
  - No RAM write occurs on an edge where `reset=1`.

## Timing
- Zero-latency combinational paths: `operand`/`rd_ram`/`sel_*`/`op` to `ram_q`, then to the ALU, then to the `acc` D input.
- One-cycle write latency: a new `acc` or RAM word is visible after the edge.
- A load followed by a store in consecutive cycles must work back to back with no stall. The store sees the loaded `acc`.
- A store to X followed by a load from X in the next cycle returns the stored value.
- Reset deassertion is synchronised externally; the block's first update happens on the first rising edge with `reset=0`.

## Test plan
- Reset and load immediate:
  - Assert `reset` mid-cycle with `acc=16'h1234`; `acc` reads 0 before the next edge.
  - Release, then LDI −1 (`sel_a=01`, `wr_acc=1`, `operand=11'h7FF`): `acc=16'hFFFF` after one edge.
- Store/load round trip:
  - `acc=16'h00A5`; STO 5 (`wr_ram=1`); LDI 0; LD 5 (`sel_a=00`, `rd_ram=1`, `operand=5`): `acc=16'h00A5`.
- Arithmetic with wrap:
  - `acc=16'h7FFF`, ADDI 1 (`sel_a=10`, `sel_b=1`, `op=0`): `acc=16'h8000`.
  - Then SUB from mem[5]=16'h8001 (`sel_b=0`, `op=1`, `rd_ram=1`): `acc=16'hFFFF`.
- Simultaneous store and accumulator write:
  - `acc=16'h0011`, one cycle with `wr_ram=1`, `wr_acc=1`, `sel_a=01`, `operand=7`: mem[7]=16'h0011 and `acc=16'h0007`.
- Out-of-range and read-disable:
  - With `RAM_DEPTH=1024`, STO 1500, then LD 1500: `acc=0` and no RAM word changes.
  - LD 5 with `rd_ram=0`: `acc=0`.
- Counter:
  - Ten cycles with `wr_pc=1`, then five with `wr_pc=0`: `inst_count=10`.
  - With `CNT_W=4`, 17 retire cycles: `inst_count=1`.
